// File: rtl/sdes_round_engine_if.sv
// rtl/sdes_round_engine_if.sv - block request / result handshake bundle for sdes_round_engine
interface sdes_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [11:0] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  modport master (
    output in_valid, in_data, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sdes_round_engine.sv
// rtl/sdes_round_engine.sv - iterative S-DES Feistel engine, one round per clock
// Optional SDES_UNROLL2_EN: two chained rounds per RUN cycle, bit-identical results.
module sdes_round_engine #(
  parameter int ROUNDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdes_round_engine_if.slave   s_bus
);

  localparam logic [4:0]  LP_LAST   = 5'(ROUNDS - 1);
  localparam logic [63:0] LP_S1_R0  = 64'hE4D12FB83A6C5907;
  localparam logic [63:0] LP_S1_R1  = 64'h0F74E2D1A6CB9538;
  localparam logic [63:0] LP_S1_R2  = 64'h41E8D62BFC973A50;
  localparam logic [63:0] LP_S1_R3  = 64'hFC8249175B3EA06D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_l;
  logic [3:0]  r_r;
  logic [11:0] r_key;
  logic        r_dec;
  logic [4:0]  r_rc;

  logic [4:0]  w_i0;
  logic [3:0]  w_r1;
  logic        w_last;

  // Column 0 sits in the most significant nibble of each row word, so shift by (15-col)*4.
  function automatic logic [3:0] sbox1(input logic [1:0] row, input logic [3:0] col);
    logic [63:0] w_row;
    logic [5:0]  w_sh;
    case (row)
      2'd0:    w_row = LP_S1_R0;
      2'd1:    w_row = LP_S1_R1;
      2'd2:    w_row = LP_S1_R2;
      default: w_row = LP_S1_R3;
    endcase
    w_sh = {~col, 2'b00};
    return 4'(w_row >> w_sh);
  endfunction

  function automatic logic [5:0] round_key(input logic [11:0] key, input logic [4:0] idx);
    logic [4:0]  w_amt;
    logic [23:0] w_dbl;
    w_amt = (idx >= 5'd12) ? idx - 5'd12 : idx;
    w_dbl = {key, key} << w_amt;
    return w_dbl[17:12];
  endfunction

  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [5:0] k);
    logic [5:0] w_x;
    logic [3:0] w_s;
    w_x = {r[3], r[2], r[2], r[1], r[1], r[0]} ^ k;
    w_s = sbox1({w_x[5], w_x[0]}, w_x[4:1]);
    return {w_s[2], w_s[1], w_s[3], w_s[0]};
  endfunction

  always_comb begin
    w_i0 = r_dec ? (LP_LAST - r_rc) : r_rc;
    w_r1 = r_l ^ f_round(r_r, round_key(r_key, w_i0));
  end

`ifdef SDES_UNROLL2_EN
  logic [4:0] w_i1;
  logic [3:0] w_r2;
  logic       w_two;

  // Second round of the pair runs only while rc+1 is still a real round.
  always_comb begin
    w_i1   = r_dec ? (LP_LAST - r_rc - 5'd1) : (r_rc + 5'd1);
    w_r2   = r_r ^ f_round(w_r1, round_key(r_key, w_i1));
    w_two  = (r_rc != LP_LAST);
    w_last = ({1'b0, r_rc} + 6'd2) >= 6'(ROUNDS);
  end
`else
  always_comb begin
    w_last = (r_rc == LP_LAST);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s_bus.in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (s_bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_bus.in_ready  = (r_state == IDLE);
    s_bus.out_valid = (r_state == DONE);
    s_bus.out_data  = {r_r, r_l};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l   <= 4'h0;
      r_r   <= 4'h0;
      r_key <= 12'h000;
      r_dec <= 1'b0;
      r_rc  <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_bus.in_valid) begin
            r_l   <= s_bus.in_data[7:4];
            r_r   <= s_bus.in_data[3:0];
            r_key <= s_bus.in_key;
            r_dec <= s_bus.in_decrypt;
            r_rc  <= 5'd0;
          end
        end
        RUN: begin
`ifdef SDES_UNROLL2_EN
          if (w_two) begin
            r_l  <= w_r1;
            r_r  <= w_r2;
            r_rc <= r_rc + 5'd2;
          end else begin
            r_l  <= r_r;
            r_r  <= w_r1;
            r_rc <= r_rc + 5'd1;
          end
`else
          r_l  <= r_r;
          r_r  <= w_r1;
          r_rc <= r_rc + 5'd1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_round_engine.sv
// tb/tb_sdes_round_engine.sv - scoreboard bench for sdes_round_engine at ROUNDS 1, 4 and 16
module tb_sdes_round_engine;

  typedef struct {
    int         g;
    logic [7:0] data;
    int         lat;
    bit         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];

  logic        t_in_valid  [3];
  logic [7:0]  t_in_data   [3];
  logic [11:0] t_in_key    [3];
  logic        t_dec       [3];
  logic        t_out_ready [3];
  logic        w_in_ready  [3];
  logic        w_out_valid [3];
  logic [7:0]  w_out_data  [3];

  int S1 [4][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdes_round_engine_if u_if0 ();
  sdes_round_engine_if u_if1 ();
  sdes_round_engine_if u_if2 ();

  sdes_round_engine #(.ROUNDS(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .s_bus(u_if0));
  sdes_round_engine #(.ROUNDS(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .s_bus(u_if1));
  sdes_round_engine #(.ROUNDS(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .s_bus(u_if2));

  assign u_if0.in_valid = t_in_valid[0];  assign u_if0.in_data = t_in_data[0];
  assign u_if0.in_key = t_in_key[0];      assign u_if0.in_decrypt = t_dec[0];
  assign u_if0.out_ready = t_out_ready[0];
  assign w_in_ready[0] = u_if0.in_ready;  assign w_out_valid[0] = u_if0.out_valid;
  assign w_out_data[0] = u_if0.out_data;

  assign u_if1.in_valid = t_in_valid[1];  assign u_if1.in_data = t_in_data[1];
  assign u_if1.in_key = t_in_key[1];      assign u_if1.in_decrypt = t_dec[1];
  assign u_if1.out_ready = t_out_ready[1];
  assign w_in_ready[1] = u_if1.in_ready;  assign w_out_valid[1] = u_if1.out_valid;
  assign w_out_data[1] = u_if1.out_data;

  assign u_if2.in_valid = t_in_valid[2];  assign u_if2.in_data = t_in_data[2];
  assign u_if2.in_key = t_in_key[2];      assign u_if2.in_decrypt = t_dec[2];
  assign u_if2.out_ready = t_out_ready[2];
  assign w_in_ready[2] = u_if2.in_ready;  assign w_out_valid[2] = u_if2.out_valid;
  assign w_out_data[2] = u_if2.out_data;

  function automatic int rnd_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
  endfunction

  function automatic int lat_of(input int g);
`ifdef SDES_UNROLL2_EN
    return (rnd_of(g) + 1) / 2;
`else
    return rnd_of(g);
`endif
  endfunction

  function automatic logic [3:0] ff(input logic [3:0] r, input logic [5:0] k);
    logic [5:0] x;
    logic [3:0] s;
    x = {r[3], r[2], r[2], r[1], r[1], r[0]} ^ k;
    s = 4'(S1[{x[5], x[0]}][x[4:1]]);
    return {s[2], s[1], s[3], s[0]};
  endfunction

  function automatic logic [7:0] model(input int rounds, input logic [7:0] d,
                                       input logic [11:0] key, input bit dec);
    logic [3:0]  l, r, t;
    logic [11:0] rk;
    int          i;
    l = d[7:4];
    r = d[3:0];
    for (int n = 0; n < rounds; n++) begin
      i  = dec ? rounds - 1 - n : n;
      rk = key;
      repeat (i % 12) rk = {rk[10:0], rk[11]};
      t  = r;
      r  = l ^ ff(r, rk[5:0]);
      l  = t;
    end
    return {r, l};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic [11:0] k, input bit dec,
                      input bit push, input bit gap, input logic [7:0] want);
    exp_t e;
    int   t;
    if (push) begin
      e.g = g; e.data = want; e.lat = lat_of(g); e.gap = gap;
      sb.push_back(e);
    end
    t_in_data[g]  = d;
    t_in_key[g]   = k;
    t_dec[g]      = dec;
    t_in_valid[g] = 1'b1;
    t = 0;
    while (!w_in_ready[g] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut%0d: got in_ready 0, want 1", g);
    end
    @(negedge clk);
    t_in_valid[g] = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    int   acc [3];
    int   rise [3];
    int   last_hs [3];
    bit   seen [3];
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      acc[g] = 0; rise[g] = 0; last_hs[g] = 0; seen[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int g = 0; g < 3; g++) begin
        if (t_in_valid[g] && w_in_ready[g]) acc[g] = cyc;
        if (!w_out_valid[g]) seen[g] = 1'b0;
        else if (!seen[g]) begin
          seen[g] = 1'b1;
          rise[g] = cyc;
        end
        if (w_out_valid[g] && t_out_ready[g]) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output dut%0d: got %h, want no output", g, w_out_data[g]);
          end else begin
            e = sb.pop_front();
            check($sformatf("source_dut%0d", g), g, e.g);
            check($sformatf("data_dut%0d", g), w_out_data[g], e.data);
            check($sformatf("latency_dut%0d", g), rise[g] - acc[g] - 1, e.lat);
            if (e.gap) check($sformatf("throughput_dut%0d", g), cyc - last_hs[g], e.lat + 2);
          end
          last_hs[g] = cyc;
          seen[g]    = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no end of test, want end before 80000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0]  d, c, bp;
    logic [11:0] k;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      t_in_valid[g] = 1'b0; t_in_data[g] = 8'h00; t_in_key[g] = 12'h000;
      t_dec[g] = 1'b0; t_out_ready[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_in_ready_dut%0d", g), w_in_ready[g], 1);
      check($sformatf("reset_out_valid_dut%0d", g), w_out_valid[g], 0);
      check($sformatf("reset_out_data_dut%0d", g), w_out_data[g], 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 8'h8D, 12'h02A, 1'b0, 1'b1, 1'b0, 8'h4D);
    wait_empty(20);
    send(0, 8'h4D, 12'h02A, 1'b1, 1'b1, 1'b0, 8'h8D);
    wait_empty(20);

    for (int g = 1; g < 3; g++) begin
      repeat (256) begin
        d = 8'($urandom);
        k = 12'($urandom);
        c = model(rnd_of(g), d, k, 1'b0);
        send(g, d, k, 1'b0, 1'b1, 1'b0, c);
        wait_empty(60);
        send(g, c, k, 1'b1, 1'b1, 1'b0, d);
        wait_empty(60);
      end
    end

    t_out_ready[1] = 1'b0;
    bp = model(4, 8'hA5, 12'h123, 1'b0);
    send(1, 8'hA5, 12'h123, 1'b0, 1'b1, 1'b0, bp);
    for (int t = 0; t < 50 && !w_out_valid[1]; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_data", w_out_data[1], bp);
      check("bp_in_ready", w_in_ready[1], 0);
      check("bp_out_valid", w_out_valid[1], 1);
      t_in_valid[1] = ~t_in_valid[1];
      t_in_data[1]  = 8'($urandom);
      @(negedge clk);
    end
    t_in_valid[1]  = 1'b0;
    t_out_ready[1] = 1'b1;
    wait_empty(50);
    repeat (3) @(negedge clk);
    check("bp_after_in_ready", w_in_ready[1], 1);
    check("bp_after_out_valid", w_out_valid[1], 0);

    send(1, 8'h3C, 12'h5A5, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_now", w_in_ready[1], 1);
    check("rst_out_valid_now", w_out_valid[1], 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready_held", w_in_ready[1], 1);
      check("rst_out_valid_held", w_out_valid[1], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    c = model(4, 8'h96, 12'hC3F, 1'b0);
    send(1, 8'h96, 12'hC3F, 1'b0, 1'b1, 1'b0, c);
    wait_empty(30);
    send(1, c, 12'hC3F, 1'b1, 1'b1, 1'b0, 8'h96);
    wait_empty(30);

    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      send(1, d, 12'h7E1, 1'b0, 1'b1, (i > 0), model(4, d, 12'h7E1, 1'b0));
    end
    wait_empty(60);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
